// File: rtl/salamander_sndcode_tx.sv
// Main-CPU sound-code transmitter: latches CPU code bytes, emits a timed SNDINT pulse, then holds the code.
// Build option: define SALAMANDER_SNDTX_FIFO_EN for a FIFO_DEPTH-entry pending queue (default: one newest-wins register).
module salamander_sndcode_tx #(
    parameter int PULSE_LEN  = 16,
    parameter int HOLD_LEN   = 4096,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_EMU_MCLK,
    input  logic       i_EMU_INITRST_n,
    input  logic       i_EMU_SOFTRST_n,
    input  logic       i_CPU_WR,
    input  logic [7:0] i_CPU_DIN,
    output logic [7:0] o_SNDCODE,
    output logic       o_SNDINT,
    output logic       o_BUSY,
    output logic       o_OVF
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [15:0] PULSE_LOAD = 16'(PULSE_LEN - 1);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_LEN - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [7:0]  code, code_nxt;
    logic        sndint, sndint_nxt;
    logic        ovf;

    logic        pend_valid;
    logic        pend_full;
    logic [7:0]  pend_head;
    logic        pop;
    logic        wr_lost;

    // A write is lost only when the store is full and the same-cycle pop does not free a slot.
    assign wr_lost = i_CPU_WR & pend_full & ~pop;

`ifdef SALAMANDER_SNDTX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          push;

    assign pend_valid = (count != '0);
    assign pend_full  = (count == CW'(FIFO_DEPTH));
    assign pend_head  = mem[rd_ptr];
    assign push       = i_CPU_WR & i_EMU_SOFTRST_n & (~pend_full | pop);

    always_ff @(posedge i_EMU_MCLK) begin
        if (push) begin
            mem[wr_ptr] <= i_CPU_DIN;
        end
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (!i_EMU_SOFTRST_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] pend_code;
    logic       pend_vld;

    assign pend_valid = pend_vld;
    assign pend_full  = pend_vld;
    assign pend_head  = pend_code;

    // Newest code wins: a write always lands, even over an unsent code.
    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            pend_vld  <= 1'b0;
            pend_code <= 8'h00;
        end else if (!i_EMU_SOFTRST_n) begin
            pend_vld  <= 1'b0;
            pend_code <= 8'h00;
        end else if (i_CPU_WR) begin
            pend_vld  <= 1'b1;
            pend_code <= i_CPU_DIN;
        end else if (pop) begin
            pend_vld  <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        code_nxt   = code;
        sndint_nxt = sndint;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    pop        = 1'b1;
                    code_nxt   = pend_head;
                    sndint_nxt = 1'b1;
                    cnt_nxt    = PULSE_LOAD;
                    state_nxt  = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt != 16'd0) begin
                    cnt_nxt = cnt - 16'd1;
                end else begin
                    sndint_nxt = 1'b0;
                    cnt_nxt    = HOLD_LOAD;
                    state_nxt  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt != 16'd0) begin
                    cnt_nxt = cnt - 16'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                sndint_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_EMU_MCLK or negedge i_EMU_INITRST_n) begin
        if (!i_EMU_INITRST_n) begin
            state  <= ST_IDLE;
            cnt    <= 16'd0;
            code   <= 8'h00;
            sndint <= 1'b0;
            ovf    <= 1'b0;
        end else if (!i_EMU_SOFTRST_n) begin
            state  <= ST_IDLE;
            cnt    <= 16'd0;
            code   <= 8'h00;
            sndint <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            code   <= code_nxt;
            sndint <= sndint_nxt;
            if (wr_lost) begin
                ovf <= 1'b1;
            end
        end
    end

    assign o_SNDCODE = code;
    assign o_SNDINT  = sndint;
    assign o_BUSY    = (state != ST_IDLE) | pend_valid;
    assign o_OVF     = ovf;

endmodule
